// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, ALU op codes, forward selects.
// Used by execute_cycle (optional perf counters via EXEC_PERF_CNT_EN) and alu.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_write;
        logic result_src;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational XLEN-bit ALU for the execute stage; unlisted op codes yield 0.
module alu #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    import riscv_pkg::*;

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, BEQ resolution and the EX/MEM register.
// Define EXEC_PERF_CNT_EN to add the Br_Count / Br_Taken_Count branch counters.
module execute_cycle #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid_E,
    input  logic              RegWrite_E,
    input  logic              MemWrite_E,
    input  logic              ResultSrc_E,
    input  logic              Branch_E,
    input  logic              ALUSrc_E,
    input  logic [2:0]        ALUControl_E,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [XLEN-1:0]   PC_E,
    input  logic [XLEN-1:0]   PCPlus4_E,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    input  logic [XLEN-1:0]   Result_W,
    input  logic              Stall_M,
    input  logic              Flush_M,
    output logic              PCSrc_E,
    output logic [XLEN-1:0]   PCTarget_E,
    output logic              Valid_M,
    output logic              RegWrite_M,
    output logic              MemWrite_M,
    output logic              ResultSrc_M,
    output logic [REG_AW-1:0] Rd_M,
    output logic [XLEN-1:0]   ALUResult_M,
    output logic [XLEN-1:0]   WriteData_M,
    output logic [XLEN-1:0]   PCPlus4_M
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]       Br_Count,
    output logic [31:0]       Br_Taken_Count
`endif
);
    import riscv_pkg::*;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            load_m;
    ex_mem_ctrl_t    ctrl_m;

    // Select code 11 is unused and falls back to the register-file value.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rd,
        input logic [XLEN-1:0] wb,
        input logic [XLEN-1:0] mem
    );
        case (sel)
            FWD_WB:  return wb;
            FWD_MEM: return mem;
            default: return rd;
        endcase
    endfunction

    assign src_a      = fwd_mux(ForwardA_E, RD1_E, Result_W, ALUResult_M);
    assign write_data = fwd_mux(ForwardB_E, RD2_E, Result_W, ALUResult_M);
    assign src_b      = ALUSrc_E ? Imm_Ext_E : write_data;

    alu #(.XLEN(XLEN)) u_alu (
        .a      (src_a),
        .b      (src_b),
        .ctrl   (ALUControl_E),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign PCSrc_E    = Valid_E & Branch_E & alu_zero;
    assign PCTarget_E = PC_E + Imm_Ext_E;
    assign load_m     = ~Flush_M & ~Stall_M;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_m      <= '0;
            Rd_M        <= '0;
            ALUResult_M <= '0;
            WriteData_M <= '0;
            PCPlus4_M   <= '0;
        end else if (Flush_M) begin
            // Bubble: kill the enables, data fields are don't-care and simply load.
            ctrl_m.valid      <= 1'b0;
            ctrl_m.reg_write  <= 1'b0;
            ctrl_m.mem_write  <= 1'b0;
            ctrl_m.result_src <= ResultSrc_E;
            Rd_M              <= Rd_E;
            ALUResult_M       <= alu_result;
            WriteData_M       <= write_data;
            PCPlus4_M         <= PCPlus4_E;
        end else if (!Stall_M) begin
            ctrl_m.valid      <= Valid_E;
            ctrl_m.reg_write  <= RegWrite_E & Valid_E;
            ctrl_m.mem_write  <= MemWrite_E & Valid_E;
            ctrl_m.result_src <= ResultSrc_E;
            Rd_M              <= Rd_E;
            ALUResult_M       <= alu_result;
            WriteData_M       <= write_data;
            PCPlus4_M         <= PCPlus4_E;
        end
    end

    assign Valid_M     = ctrl_m.valid;
    assign RegWrite_M  = ctrl_m.reg_write;
    assign MemWrite_M  = ctrl_m.mem_write;
    assign ResultSrc_M = ctrl_m.result_src;

`ifdef EXEC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Br_Count       <= '0;
            Br_Taken_Count <= '0;
        end else if (load_m) begin
            Br_Count       <= Br_Count + {31'd0, Valid_E & Branch_E};
            Br_Taken_Count <= Br_Taken_Count + {31'd0, PCSrc_E};
        end
    end
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed steps plus random traffic vs a behavioural model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        Valid_E, RegWrite_E, MemWrite_E, ResultSrc_E, Branch_E, ALUSrc_E;
    logic [2:0]  ALUControl_E;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E, Result_W;
    logic [4:0]  Rd_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        Stall_M, Flush_M;
    logic        PCSrc_E;
    logic [31:0] PCTarget_E;
    logic        Valid_M, RegWrite_M, MemWrite_M, ResultSrc_M;
    logic [4:0]  Rd_M;
    logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M;
`ifdef EXEC_PERF_CNT_EN
    logic [31:0] Br_Count, Br_Taken_Count;
`endif

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst), .Valid_E(Valid_E), .RegWrite_E(RegWrite_E),
        .MemWrite_E(MemWrite_E), .ResultSrc_E(ResultSrc_E), .Branch_E(Branch_E),
        .ALUSrc_E(ALUSrc_E), .ALUControl_E(ALUControl_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .Rd_E(Rd_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Result_W(Result_W),
        .Stall_M(Stall_M), .Flush_M(Flush_M), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
        .Valid_M(Valid_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
        .ResultSrc_M(ResultSrc_M), .Rd_M(Rd_M), .ALUResult_M(ALUResult_M),
        .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M)
`ifdef EXEC_PERF_CNT_EN
        , .Br_Count(Br_Count), .Br_Taken_Count(Br_Taken_Count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Expected EX/MEM contents; data_known drops after a flush (data is don't-care then).
    logic        m_valid, m_rw, m_mw, m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc4;
    bit          data_known;
    int unsigned br_cnt, tk_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rd);
        if (sel == 2'd1) return Result_W;
        if (sel == 2'd2) return m_alu;
        return rd;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0;
        m_alu = 0; m_wd = 0; m_pc4 = 0; data_known = 1;
        br_cnt = 0; tk_cnt = 0;
    endtask

    task automatic check_m(input string tag);
        chk({tag, ".Valid_M"}, {31'd0, Valid_M}, {31'd0, m_valid});
        chk({tag, ".RegWrite_M"}, {31'd0, RegWrite_M}, {31'd0, m_rw});
        chk({tag, ".MemWrite_M"}, {31'd0, MemWrite_M}, {31'd0, m_mw});
        if (data_known) begin
            chk({tag, ".ResultSrc_M"}, {31'd0, ResultSrc_M}, {31'd0, m_rs});
            chk({tag, ".Rd_M"}, {27'd0, Rd_M}, {27'd0, m_rd});
            chk({tag, ".ALUResult_M"}, ALUResult_M, m_alu);
            chk({tag, ".WriteData_M"}, WriteData_M, m_wd);
            chk({tag, ".PCPlus4_M"}, PCPlus4_M, m_pc4);
        end
`ifdef EXEC_PERF_CNT_EN
        chk({tag, ".Br_Count"}, Br_Count, br_cnt);
        chk({tag, ".Br_Taken_Count"}, Br_Taken_Count, tk_cnt);
`endif
    endtask

    // Check same-cycle branch outputs, advance one clock, then check the EX/MEM contents.
    task automatic cycle(input string tag);
        logic [31:0] a, wd, b, res;
        logic        taken;
        #1;
        a     = ref_fwd(ForwardA_E, RD1_E);
        wd    = ref_fwd(ForwardB_E, RD2_E);
        b     = ALUSrc_E ? Imm_Ext_E : wd;
        res   = ref_alu(ALUControl_E, a, b);
        taken = Valid_E && Branch_E && (res == 0);
        chk({tag, ".PCSrc_E"}, {31'd0, PCSrc_E}, {31'd0, taken});
        chk({tag, ".PCTarget_E"}, PCTarget_E, PC_E + Imm_Ext_E);
        if (Flush_M) begin
            m_valid = 0; m_rw = 0; m_mw = 0; data_known = 0;
        end else if (!Stall_M) begin
            m_valid = Valid_E; m_rw = RegWrite_E && Valid_E; m_mw = MemWrite_E && Valid_E;
            m_rs = ResultSrc_E; m_rd = Rd_E; m_alu = res; m_wd = wd; m_pc4 = PCPlus4_E;
            data_known = 1;
            br_cnt += (Valid_E && Branch_E) ? 1 : 0;
            tk_cnt += taken ? 1 : 0;
        end
        @(posedge clk);
        #1;
        check_m(tag);
    endtask

    task automatic set_nop();
        Valid_E = 0; RegWrite_E = 0; MemWrite_E = 0; ResultSrc_E = 0; Branch_E = 0;
        ALUSrc_E = 0; ALUControl_E = 3'd0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
        PC_E = 0; PCPlus4_E = 4; Rd_E = 0; ForwardA_E = 0; ForwardB_E = 0;
        Result_W = 0; Stall_M = 0; Flush_M = 0;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                          input logic src, input logic [31:0] imm);
        set_nop();
        Valid_E = 1; RegWrite_E = 1; ALUControl_E = op; RD1_E = r1; RD2_E = r2;
        ALUSrc_E = src; Imm_Ext_E = imm; Rd_E = 5'd7; PC_E = 32'h40; PCPlus4_E = 32'h44;
    endtask

    task automatic set_beq(input logic [31:0] r1, input logic [31:0] r2);
        set_op(3'd1, r1, r2, 1'b0, 32'h8);
        RegWrite_E = 0; Branch_E = 1; PC_E = 32'h100; PCPlus4_E = 32'h104;
    endtask

    initial begin
        set_nop();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_m("reset");
        rst = 0;

        // Reset asserted asynchronously in mid-cycle while a valid add sits in EX/MEM.
        set_op(3'd0, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFD);
        cycle("pre_rst_add");
        chk("pre_rst_add.lit", ALUResult_M, 32'd2);
        #2 rst = 1;
        model_reset();
        #1 check_m("async_rst");
        @(posedge clk);
        #1 check_m("rst_held");
        #2 rst = 0;
        #1 check_m("rst_released");

        set_op(3'd0, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFD);
        cycle("add");
        chk("add.lit", ALUResult_M, 32'd2);
        chk("add.valid", {31'd0, Valid_M}, 32'd1);
        set_op(3'd1, 32'd3, 32'd5, 1'b0, 32'd0);
        cycle("sub");
        chk("sub.lit", ALUResult_M, 32'hFFFFFFFE);
        set_op(3'd5, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0);
        cycle("slt");
        chk("slt.lit", ALUResult_M, 32'd1);
        set_op(3'd7, 32'h1234, 32'h55, 1'b0, 32'd0);
        cycle("op_undef");

        set_op(3'd0, 32'h10, 32'd0, 1'b1, 32'd0);
        cycle("fwd_prep");
        set_op(3'd0, 32'h99, 32'h4, 1'b0, 32'd0);
        ForwardA_E = 2'b10;
        cycle("fwdA_mem");
        chk("fwdA_mem.lit", ALUResult_M, 32'h14);
        set_op(3'd0, 32'h3, 32'h99, 1'b1, 32'h10);
        RegWrite_E = 0; MemWrite_E = 1; ForwardB_E = 2'b01; Result_W = 32'd7;
        cycle("fwdB_wb_store");
        chk("fwdB_wb_store.lit", WriteData_M, 32'd7);
        set_op(3'd0, 32'h21, 32'h2, 1'b0, 32'd0);
        ForwardA_E = 2'b11; ForwardB_E = 2'b11; Result_W = 32'hDEAD;
        cycle("fwd_11");
        chk("fwd_11.lit", ALUResult_M, 32'h23);

        set_beq(32'h20, 32'h20);
        #1;
        chk("beq.same_cycle", {31'd0, PCSrc_E}, 32'd1);
        chk("beq.target", PCTarget_E, 32'h108);
        cycle("beq_taken");
        set_beq(32'h20, 32'h20);
        Valid_E = 0; RegWrite_E = 1; MemWrite_E = 1;
        cycle("beq_invalid");
        chk("beq_invalid.pcsrc", {31'd0, PCSrc_E}, 32'd0);

        set_op(3'd3, 32'hF0, 32'h0F, 1'b0, 32'd0);
        MemWrite_E = 1;
        cycle("pre_stall");
        for (int i = 0; i < 3; i++) begin
            set_op(3'd0, $urandom, $urandom, 1'b0, 32'd0);
            Stall_M = 1;
            cycle("stall");
            chk("stall.alu_lit", ALUResult_M, 32'hFF);
        end
        set_op(3'd0, 32'd1, 32'd1, 1'b0, 32'd0);
        MemWrite_E = 1; Stall_M = 1; Flush_M = 1;
        cycle("flush_stall");
        chk("flush_stall.valid_lit", {31'd0, Valid_M}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            set_nop();
            Valid_E = $urandom_range(0, 3) != 0;
            RegWrite_E = $urandom_range(0, 1) == 1;
            MemWrite_E = $urandom_range(0, 1) == 1;
            ResultSrc_E = $urandom_range(0, 1) == 1;
            Branch_E = $urandom_range(0, 2) == 0;
            ALUSrc_E = $urandom_range(0, 1) == 1;
            ALUControl_E = 3'($urandom_range(0, 7));
            RD1_E = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4));
            RD2_E = ($urandom_range(0, 2) == 0) ? RD1_E : $urandom;
            Imm_Ext_E = $urandom; PC_E = $urandom; PCPlus4_E = PC_E + 4;
            Rd_E = 5'($urandom); Result_W = $urandom;
            ForwardA_E = 2'($urandom_range(0, 3));
            ForwardB_E = 2'($urandom_range(0, 3));
            if (!data_known && ForwardA_E == 2'b10) ForwardA_E = 2'b00;
            if (!data_known && ForwardB_E == 2'b10) ForwardB_E = 2'b00;
            Stall_M = $urandom_range(0, 5) == 0;
            Flush_M = $urandom_range(0, 7) == 0;
            cycle("rand");
        end

`ifdef EXEC_PERF_CNT_EN
        set_nop();
        rst = 1;
        model_reset();
        #2 rst = 0;
        set_beq(32'h5, 32'h5);  cycle("perf_b1");
        set_beq(32'h5, 32'h6);  cycle("perf_b2");
        set_beq(32'h9, 32'h9);  Stall_M = 1; cycle("perf_b3_stalled");
        set_beq(32'h9, 32'h9);  cycle("perf_b3");
        set_beq(32'h1, 32'h2);  cycle("perf_b4");
        set_nop();              cycle("perf_idle");
        chk("perf.br_lit", Br_Count, 32'd4);
        chk("perf.taken_lit", Br_Taken_Count, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
